// File: rtl/cornet_bus_arbiter.sv
// Two-master arbiter/sequencer for the Cornet 16-bit address / 8-bit data memory bus.
// Latency: request seen in IDLE at T, strobe at T+1, ready sampled from T+2, ack at T+3 (4 cycles/transfer best case).
// Backpressure: mem_ready low stretches WAIT; masters hold req until their one-cycle ack; TIMEOUT WAIT cycles aborts.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   mN_req/wr/addr/wdata              master N request (N=0 high priority, N=1 CPU); held until mN_ack
//   mN_ack, mN_rdata                  one-cycle completion pulse, read data (valid at ack, held until next read)
//   mem_addr/wr_data/wr_en/rd_req     memory command; strobes are one cycle per transfer
//   mem_rd_data, mem_ready            memory read data and ready (low while busy)
//   grant                             one-hot owner from ISSUE through DONE, 00 when idle
//   timeout_err                       one-cycle pulse alongside the ack of an aborted transfer
module cornet_bus_arbiter #(
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [15:0] m0_addr,
  input  logic [7:0]  m0_wdata,
  output logic        m0_ack,
  output logic [7:0]  m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [15:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  output logic        m1_ack,
  output logic [7:0]  m1_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wr_data,
  output logic        mem_wr_en,
  output logic        mem_rd_req,
  input  logic [7:0]  mem_rd_data,
  input  logic        mem_ready,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);
  // Counter value seen in the last permitted WAIT cycle.
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;     // 0 = master 0, 1 = master 1
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [3:0]  burst_q, burst_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic        to_flag_q, to_flag_d;
  logic [7:0]  m0_rdata_q, m0_rdata_d;
  logic [7:0]  m1_rdata_q, m1_rdata_d;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      burst_q    <= '0;
      to_cnt_q   <= '0;
      to_flag_q  <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      burst_q    <= burst_d;
      to_cnt_q   <= to_cnt_d;
      to_flag_q  <= to_flag_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    burst_d    = burst_q;
    to_cnt_d   = to_cnt_q;
    to_flag_d  = to_flag_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (!m1_req) burst_d = '0;
        if (m0_req && (!m1_req || burst_q != BURST_LIM)) begin
          state_d = S_ISSUE;
          owner_d = 1'b0;
          wr_d    = m0_wr;
          addr_d  = m0_addr;
          wdata_d = m0_wdata;
          // m0 only wins against a waiting m1 below the limit, so this never passes BURST_LIM.
          if (m1_req) burst_d = burst_q + 4'd1;
        end else if (m1_req) begin
          state_d = S_ISSUE;
          owner_d = 1'b1;
          wr_d    = m1_wr;
          addr_d  = m1_addr;
          wdata_d = m1_wdata;
          burst_d = '0;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // Ready wins over the timeout when both land in the same cycle.
        if (mem_ready) begin
          state_d  = S_DONE;
          to_cnt_d = '0;
          if (!wr_q) begin
            if (owner_q) m1_rdata_d = mem_rd_data;
            else         m0_rdata_d = mem_rd_data;
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d   = S_DONE;
          to_cnt_d  = '0;
          to_flag_d = 1'b1;
          if (!wr_q) begin
            if (owner_q) m1_rdata_d = 8'hFF;
            else         m0_rdata_d = 8'hFF;
          end
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        to_flag_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: strobes, grant and acks depend on state only, so reset clears them at once.
  always_comb begin
    grant       = 2'b00;
    mem_rd_req  = 1'b0;
    mem_wr_en   = 1'b0;
    m0_ack      = 1'b0;
    m1_ack      = 1'b0;
    timeout_err = 1'b0;
    if (state_q != S_IDLE) grant = owner_q ? 2'b10 : 2'b01;
    if (state_q == S_ISSUE) begin
      mem_rd_req = !wr_q;
      mem_wr_en  = wr_q;
    end
    if (state_q == S_DONE) begin
      m0_ack      = !owner_q;
      m1_ack      = owner_q;
      timeout_err = to_flag_q;
    end
  end

  assign mem_addr    = addr_q;
  assign mem_wr_data = wdata_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;

endmodule
